antares_muldiv_unit: RTL and testbench

- Parametrised HI/LO execution unit for the EX stage of the Antares pipeline. It holds the HILO accumulator.
- Supported operations:
  - Pipelined multiply and multiply-accumulate/subtract.
  - Iterative restoring divide.
  - HI/LO moves.
- Provides a busy/stall handshake toward the pipeline.
- Replaces the fixed 32-bit HILO logic embedded in the ALU.
- Accumulate operations read HILO only at completion, so back-to-back MADD/MSUB chains are correct.

---
 rtl/antares_muldiv_unit.sv | 211 +++++++++++++++++++++
 tb/tb_antares_muldiv_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/antares_muldiv_unit.sv
// HI/LO execution unit for the Antares EX stage: pipelined multiply/accumulate,
// iterative restoring divide and HI/LO moves, with busy/stall handshake.
//
// div state | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no divide in flight
// RUN       | W iterations, one quotient bit per cycle on magnitudes
// FIX       | apply sign correction, write {remainder, quotient} to HILO
module antares_muldiv_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int MULT_LATENCY = 2,
  parameter int ENABLE_MULT  = 1,
  parameter int ENABLE_DIV   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  input  logic [3:0]            op_code,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  ex_stall,
  input  logic                  ex_flush,
  output logic                  request_stall,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int L  = MULT_LATENCY;
  localparam int CW = $clog2(W);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MADD  = 4'd3;
  localparam logic [3:0] OP_MADDU = 4'd4;
  localparam logic [3:0] OP_MSUB  = 4'd5;
  localparam logic [3:0] OP_MSUBU = 4'd6;
  localparam logic [3:0] OP_DIV   = 4'd7;
  localparam logic [3:0] OP_DIVU  = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;
  localparam logic [3:0] OP_MFHI  = 4'd11;
  localparam logic [3:0] OP_MFLO  = 4'd12;

  localparam logic [1:0] KIND_SET = 2'd0;
  localparam logic [1:0] KIND_ADD = 2'd1;
  localparam logic [1:0] KIND_SUB = 2'd2;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [2*W-1:0] hilo;

  logic           is_hilo_op;
  logic           accept;
  logic           mul_op;
  logic           mul_signed;
  logic [1:0]     mul_kind;
  logic           div_op;
  logic           div_signed;
  logic           mul_issue;
  logic           div_issue;

  logic [2*W-1:0] mul_a_ext;
  logic [2*W-1:0] mul_b_ext;
  logic [2*W-1:0] mul_prod;

  logic [L-1:0]   mul_vld_q;
  logic [2*W-1:0] mul_prod_q [L];
  logic [1:0]     mul_kind_q [L];
  logic           mul_commit;

  logic [1:0]     div_state;
  logic [CW-1:0]  div_cnt;
  logic [W-1:0]   div_quo;
  logic [W-1:0]   div_rem;
  logic [W-1:0]   div_dvs;
  logic           div_qneg;
  logic           div_rneg;
  logic [W-1:0]   div_a_mag;
  logic [W-1:0]   div_b_mag;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic [W-1:0]   div_q_fix;
  logic [W-1:0]   div_r_fix;
  logic           div_commit;

  always_comb begin
    is_hilo_op = (op_code >= OP_MULT) && (op_code <= OP_MFLO);
    mul_op     = (ENABLE_MULT != 0) && (op_code >= OP_MULT) && (op_code <= OP_MSUBU);
    mul_signed = (op_code == OP_MULT) || (op_code == OP_MADD) || (op_code == OP_MSUB);
    div_op     = (ENABLE_DIV != 0) && ((op_code == OP_DIV) || (op_code == OP_DIVU));
    div_signed = (op_code == OP_DIV);
    mul_kind   = KIND_SET;
    if ((op_code == OP_MADD) || (op_code == OP_MADDU)) mul_kind = KIND_ADD;
    if ((op_code == OP_MSUB) || (op_code == OP_MSUBU)) mul_kind = KIND_SUB;
  end

  assign accept        = op_valid & is_hilo_op & ~ex_stall & ~ex_flush & ~busy;
  assign request_stall = op_valid & is_hilo_op & busy;
  assign mul_issue     = accept & mul_op;
  // A zero divisor is swallowed at issue: no busy, no done, HILO untouched.
  assign div_issue     = accept & div_op & (op_b != '0);

  // Truncated 2W-bit product of extended operands is the correct signed/unsigned result.
  assign mul_a_ext = mul_signed ? {{W{op_a[W-1]}}, op_a} : {{W{1'b0}}, op_a};
  assign mul_b_ext = mul_signed ? {{W{op_b[W-1]}}, op_b} : {{W{1'b0}}, op_b};
  assign mul_prod  = mul_a_ext * mul_b_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_vld_q <= '0;
    end else begin
      mul_vld_q[0] <= mul_issue;
      for (int k = 1; k < L; k++) mul_vld_q[k] <= mul_vld_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    mul_prod_q[0] <= mul_prod;
    mul_kind_q[0] <= mul_kind;
    for (int k = 1; k < L; k++) begin
      mul_prod_q[k] <= mul_prod_q[k-1];
      mul_kind_q[k] <= mul_kind_q[k-1];
    end
  end

  assign mul_commit = mul_vld_q[L-1];

  assign div_a_mag  = (div_signed && op_a[W-1]) ? -op_a : op_a;
  assign div_b_mag  = (div_signed && op_b[W-1]) ? -op_b : op_b;
  assign div_shift  = {div_rem, div_quo[W-1]};
  assign div_diff   = div_shift - {1'b0, div_dvs};
  assign div_q_fix  = div_qneg ? -div_quo : div_quo;
  assign div_r_fix  = div_rneg ? -div_rem : div_rem;
  assign div_commit = (div_state == DIV_FIX);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_state <= DIV_IDLE;
    end else begin
      case (div_state)
        DIV_IDLE: if (div_issue) div_state <= DIV_RUN;
        DIV_RUN:  if (div_cnt == '0) div_state <= DIV_FIX;
        DIV_FIX:  div_state <= DIV_IDLE;
        default:  div_state <= DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((div_state == DIV_IDLE) && div_issue) begin
      div_quo  <= div_a_mag;
      div_rem  <= '0;
      div_dvs  <= div_b_mag;
      div_cnt  <= CNT_LAST;
      div_qneg <= div_signed & (op_a[W-1] ^ op_b[W-1]);
      div_rneg <= div_signed & op_a[W-1];
    end else if (div_state == DIV_RUN) begin
      div_cnt <= div_cnt - CNT_ONE;
      if (!div_diff[W]) begin
        div_rem <= div_diff[W-1:0];
        div_quo <= {div_quo[W-2:0], 1'b1};
      end else begin
        div_rem <= div_shift[W-1:0];
        div_quo <= {div_quo[W-2:0], 1'b0};
      end
    end
  end

  // Accumulates read HILO only at commit, so back-to-back MADD/MSUB chains see fresh data.
  always_ff @(posedge clk) begin
    if (rst) begin
      hilo <= '0;
      done <= 1'b0;
    end else begin
      done <= mul_commit | div_commit;
      if (mul_commit) begin
        case (mul_kind_q[L-1])
          KIND_ADD: hilo <= hilo + mul_prod_q[L-1];
          KIND_SUB: hilo <= hilo - mul_prod_q[L-1];
          default:  hilo <= mul_prod_q[L-1];
        endcase
      end else if (div_commit) begin
        hilo <= {div_r_fix, div_q_fix};
      end else if (accept && (op_code == OP_MTHI)) begin
        hilo[2*W-1:W] <= op_a;
      end else if (accept && (op_code == OP_MTLO)) begin
        hilo[W-1:0] <= op_a;
      end
    end
  end

  assign busy = (|mul_vld_q) | (div_state != DIV_IDLE);
  assign hi   = hilo[2*W-1:W];
  assign lo   = hilo[W-1:0];

  always_comb begin
    result = '0;
    if (op_code == OP_MFHI) result = hi;
    if (op_code == OP_MFLO) result = lo;
  end

endmodule

// File: tb/tb_antares_muldiv_unit.sv
// Directed bench for antares_muldiv_unit (W=32, MULT_LATENCY=2) with
// hand-computed HILO values and cycle counts.
module tb_antares_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ex_stall;
  logic        ex_flush;
  logic        request_stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  antares_muldiv_unit #(
    .DATA_WIDTH(32),
    .MULT_LATENCY(2),
    .ENABLE_MULT(1),
    .ENABLE_DIV(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .op_valid(op_valid),
    .op_code(op_code),
    .op_a(op_a),
    .op_b(op_b),
    .ex_stall(ex_stall),
    .ex_flush(ex_flush),
    .request_stall(request_stall),
    .busy(busy),
    .done(done),
    .result(result),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op_code  = op;
    op_a     = a;
    op_b     = b;
    tick();
    op_valid = 1'b0;
    op_code  = 4'd0;
    op_a     = '0;
    op_b     = '0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
  endtask

  initial begin
    int cyc;
    int dn;

    rst = 1'b1; op_valid = 1'b0; op_code = 4'd0; op_a = '0; op_b = '0;
    ex_stall = 1'b0; ex_flush = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    check("reset_hilo", {hi, lo}, 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);

    // MULT -2 * 3
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy_e0", 64'(busy), 64'h1);
    check("mult_done_e0", 64'(done), 64'h0);
    wait_idle(cyc);
    check("mult_busy_cycles", 64'(cyc), 64'd2);
    check("mult_done", 64'(done), 64'h1);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    tick();
    check("mult_done_pulse", 64'(done), 64'h0);
    op_valid = 1'b1; op_code = 4'd12; #1;
    check("mflo", 64'(result), 64'h0000_0000_FFFF_FFFA);
    op_code = 4'd11; #1;
    check("mfhi", 64'(result), 64'h0000_0000_FFFF_FFFF);
    op_code = 4'd1; #1;
    check("result_zero", 64'(result), 64'h0);
    op_valid = 1'b0; op_code = 4'd0;

    // MTHI/MTLO, MADDU then MSUB presented while busy
    issue(4'd9, 32'd0, 32'd0);
    issue(4'd10, 32'd10, 32'd0);
    check("mthi_mtlo", {hi, lo}, 64'h0000_0000_0000_000A);
    issue(4'd4, 32'hFFFF_FFFF, 32'd2);
    op_valid = 1'b1; op_code = 4'd5; op_a = 32'd1; op_b = 32'd1; #1;
    check("req_stall_busy", 64'(request_stall), 64'h1);
    cyc = 0;
    while (request_stall === 1'b1 && cyc < 50) begin
      cyc++;
      tick();
    end
    check("req_stall_cycles", 64'(cyc), 64'd2);
    check("maddu_done", 64'(done), 64'h1);
    check("maddu_hilo", {hi, lo}, 64'h0000_0002_0000_0008);
    tick();
    op_valid = 1'b0; op_code = 4'd0; op_a = '0; op_b = '0;
    check("msub_busy", 64'(busy), 64'h1);
    wait_idle(cyc);
    check("msub_cycles", 64'(cyc), 64'd2);
    check("msub_hilo", {hi, lo}, 64'h0000_0002_0000_0007);

    // DIV -7 / 2
    issue(4'd7, 32'hFFFF_FFF9, 32'd2);
    wait_idle(cyc);
    check("div_busy_cycles", 64'(cyc), 64'd33);
    check("div_done", 64'(done), 64'h1);
    check("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // DIV 7 / -2
    issue(4'd7, 32'd7, 32'hFFFF_FFFE);
    wait_idle(cyc);
    check("div_negb_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

    // DIVU by zero is a NOP
    issue(4'd8, 32'd7, 32'd0);
    check("divz_busy", 64'(busy), 64'h0);
    tick(); tick();
    check("divz_done", 64'(done), 64'h0);
    check("divz_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

    // DIV MIN / -1
    issue(4'd7, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(cyc);
    check("div_min_cycles", 64'(cyc), 64'd33);
    check("div_min_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    // DIVU 0xFFFFFFFF / 10
    issue(4'd8, 32'hFFFF_FFFF, 32'd10);
    wait_idle(cyc);
    check("divu_hilo", {hi, lo}, 64'h0000_0005_1999_9999);

    // MULT with flush, MTHI with stall: neither accepted
    ex_flush = 1'b1; op_valid = 1'b1; op_code = 4'd1; op_a = 32'd5; op_b = 32'd5; #1;
    check("flush_no_req", 64'(request_stall), 64'h0);
    tick();
    ex_flush = 1'b0; op_valid = 1'b0; op_code = 4'd0;
    check("flush_busy", 64'(busy), 64'h0);
    tick();
    check("flush_done", 64'(done), 64'h0);
    check("flush_hilo", {hi, lo}, 64'h0000_0005_1999_9999);
    ex_stall = 1'b1; op_valid = 1'b1; op_code = 4'd9; op_a = 32'hDEAD_BEEF;
    tick();
    ex_stall = 1'b0; op_valid = 1'b0; op_code = 4'd0; op_a = '0;
    check("stall_hi", 64'(hi), 64'h5);

    // flush/stall mid-DIVU do not abort it
    issue(4'd8, 32'd100, 32'd7);
    tick(); tick(); tick();
    ex_flush = 1'b1; ex_stall = 1'b1;
    op_valid = 1'b1; op_code = 4'd1; op_a = 32'd3; op_b = 32'd3; #1;
    check("req_stall_flush", 64'(request_stall), 64'h1);
    wait_idle(cyc);
    check("divu_flush_cycles", 64'(cyc), 64'd30);
    check("divu_flush_hilo", {hi, lo}, 64'h0000_0002_0000_000E);
    tick();
    check("flush_blocks_issue", 64'(busy), 64'h0);
    ex_flush = 1'b0; ex_stall = 1'b0; op_valid = 1'b0; op_code = 4'd0; op_a = '0; op_b = '0;

    // reset at cycle 10 of a DIV
    issue(4'd7, 32'd1000, 32'd3);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_done", 64'(done), 64'h0);
    issue(4'd10, 32'd5, 32'd0);
    check("rst_mtlo", {hi, lo}, 64'h0000_0000_0000_0005);
    dn = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) dn++;
    end
    check("rst_no_done", 64'(dn), 64'd0);
    check("rst_final_hilo", {hi, lo}, 64'h0000_0000_0000_0005);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
